// File: rtl/act_pkg.sv
// Shared definitions for the hard activation pipeline: mode encoding and the
// fixed-point reciprocal used to divide by six without a divider.
package act_pkg;

  typedef enum logic [2:0] {
    MODE_BYPASS   = 3'd0,
    MODE_RELU     = 3'd1,
    MODE_RELU6    = 3'd2,
    MODE_HSIGMOID = 3'd3,
    MODE_HSWISH   = 3'd4
  } act_mode_e;

  // round(2^16 / 6); multiplying by R6 and shifting by RECIP_SHIFT divides by six
  localparam int R6          = 10923;
  localparam int RECIP_SHIFT = 16;

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: S1 clamp, S2 multiply, S3 scale/select/saturate.
// Stage valid bits live in the parent; this lane only moves data when adv is high.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [2:0]            s2_mode,
  output logic [DATA_WIDTH-1:0] out_y
);

  localparam int W   = 2*DATA_WIDTH + 18;
  localparam int EXT = W - DATA_WIDTH;
  localparam logic signed [W-1:0] THREE = W'(3 * (2 ** FRAC_BITS));
  localparam logic signed [W-1:0] SIX   = W'(6 * (2 ** FRAC_BITS));
  localparam logic signed [W-1:0] R6_W  = W'(R6);
  localparam logic signed [W-1:0] MAXV  = W'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [W-1:0] MINV  = ~MAXV;

  logic signed [W-1:0]   x_w, t_raw, t_c, r6_c;
  logic [DATA_WIDTH-1:0] x_s1, x_s2;
  logic signed [W-1:0]   t_s1, r6_s1;
  logic signed [W-1:0]   x1_w, sig_c, swish_c;
  logic signed [W-1:0]   r6_s2, sig_s2, swish_s2;
  logic signed [W-1:0]   x2_w, sel;
  logic [DATA_WIDTH-1:0] y_c;

  // S1: t = clamp(x + 3, 0, 6) and relu6 = clamp(x, 0, 6), both in the lane Q-format
  always_comb begin
    x_w   = {{EXT{in_x[DATA_WIDTH-1]}}, in_x};
    t_raw = x_w + THREE;
    t_c   = t_raw;
    if (t_raw[W-1])       t_c = '0;
    else if (t_raw > SIX) t_c = SIX;
    r6_c = x_w;
    if (x_w[W-1])         r6_c = '0;
    else if (x_w > SIX)   r6_c = SIX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_s1  <= '0;
      t_s1  <= '0;
      r6_s1 <= '0;
    end else if (adv) begin
      x_s1  <= in_x;
      t_s1  <= t_c;
      r6_s1 <= r6_c;
    end
  end

  always_comb begin
    x1_w    = {{EXT{x_s1[DATA_WIDTH-1]}}, x_s1};
    sig_c   = t_s1 * R6_W;
    swish_c = x1_w * t_s1 * R6_W;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_s2     <= '0;
      r6_s2    <= '0;
      sig_s2   <= '0;
      swish_s2 <= '0;
    end else if (adv) begin
      x_s2     <= x_s1;
      r6_s2    <= r6_s1;
      sig_s2   <= sig_c;
      swish_s2 <= swish_c;
    end
  end

  // S3: floor shifts undo the reciprocal scaling; unused modes produce zero
  always_comb begin
    x2_w = {{EXT{x_s2[DATA_WIDTH-1]}}, x_s2};
    sel  = '0;
    case (act_mode_e'(s2_mode))
      MODE_BYPASS:   sel = x2_w;
      MODE_RELU:     sel = x2_w[W-1] ? '0 : x2_w;
      MODE_RELU6:    sel = r6_s2;
      MODE_HSIGMOID: sel = sig_s2 >>> RECIP_SHIFT;
      MODE_HSWISH:   sel = swish_s2 >>> (FRAC_BITS + RECIP_SHIFT);
      default:       sel = '0;
    endcase
    y_c = sel[DATA_WIDTH-1:0];
    if (sel > MAXV)      y_c = MAXV[DATA_WIDTH-1:0];
    else if (sel < MINV) y_c = MINV[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      out_y <= '0;
    else if (adv) out_y <= y_c;
  end

endmodule

// File: rtl/hard_act_pipe.sv
// Three-stage hard activation pipeline over LANES parallel lanes; valid, mode and
// last travel alongside the data and every stage advances together on adv.
module hard_act_pipe
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [2:0]                  in_mode,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic       adv;
  logic       v1, v2;
  logic [2:0] mode1, mode2;
  logic       last1, last2;

  // A stall only happens when the output holds a beat nobody is taking
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      mode1     <= '0;
      mode2     <= '0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      mode1     <= in_mode;
      mode2     <= mode1;
      last1     <= in_last;
      last2     <= last1;
      out_last  <= last2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .in_x   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .s2_mode(mode2),
      .out_y  (out_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_hard_act_pipe.sv
// Bench for hard_act_pipe: default 16/8 instance driven through a scoreboard, plus an
// 8-bit/4-fraction instance for narrow-lane saturation and lane independence.
module tb_hard_act_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [2:0]  in_mode;
  logic        in_last, in_valid, in_ready;
  logic [63:0] out_data;
  logic        out_last, out_valid, out_ready;

  logic [31:0] d8_in_data, d8_out_data;
  logic [2:0]  d8_in_mode;
  logic        d8_in_last, d8_in_valid, d8_in_ready;
  logic        d8_out_last, d8_out_valid, d8_out_ready;

  always #5 clk = ~clk;

  hard_act_pipe #(.DATA_WIDTH(16), .FRAC_BITS(8), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  hard_act_pipe #(.DATA_WIDTH(8), .FRAC_BITS(4), .LANES(4)) dut8 (
    .clk(clk), .rst(rst), .in_data(d8_in_data), .in_mode(d8_in_mode), .in_last(d8_in_last),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .out_data(d8_out_data),
    .out_last(d8_out_last), .out_valid(d8_out_valid), .out_ready(d8_out_ready)
  );

  typedef struct {
    logic [63:0] data;
    logic [2:0]  mode;
    logic        last;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [9];
  logic [64:0] sb_q [$];
  int          checks = 0;
  int          passes = 0;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Reference activation in plain 64-bit arithmetic
  function automatic longint ref_act(input longint x, input int m, input int dw, input int frac);
    longint one, t, r6, y, hi, lo;
    one = longint'(1) <<< frac;
    t   = x + 3*one;
    if (t < 0) t = 0; else if (t > 6*one) t = 6*one;
    r6 = x;
    if (r6 < 0) r6 = 0; else if (r6 > 6*one) r6 = 6*one;
    case (m)
      0:       y = x;
      1:       y = (x < 0) ? 0 : x;
      2:       y = r6;
      3:       y = (t * 10923) >>> 16;
      4:       y = (x * t * 10923) >>> (frac + 16);
      default: y = 0;
    endcase
    hi = (longint'(1) <<< (dw-1)) - 1;
    lo = -hi - 1;
    if (y > hi) y = hi; else if (y < lo) y = lo;
    return y;
  endfunction

  function automatic logic [63:0] model_beat(input logic [63:0] d, input logic [2:0] m);
    logic [63:0]        r;
    logic signed [15:0] xs;
    longint             y;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      xs = d[i*16 +: 16];
      y  = ref_act(longint'(xs), int'(m), 16, 8);
      r[i*16 +: 16] = y[15:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one beat, wait for its acceptance and record the expected result
  task automatic applyStimulus(input logic [63:0] d, input logic [2:0] m, input logic l,
                               input logic [63:0] e);
    logic acc;
    acc = 1'b0;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb_q.push_back({l, e});
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic waitDrain(input string name);
    for (int n = 0; n < 50; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 65'(sb_q.size()), 65'(0));
  endtask

  task automatic runD8(input string name, input logic [31:0] d, input logic [2:0] m,
                       input logic [31:0] e);
    logic seen;
    seen = 1'b0;
    d8_in_data  = d;
    d8_in_mode  = m;
    d8_in_last  = 1'b1;
    d8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d8_in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (d8_out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, seen ? {32'b0, d8_out_last, d8_out_data} : 65'h1_dead_beef,
                {32'b0, 1'b1, e});
  endtask

  // Scoreboard: every beat leaving the DUT must match the oldest expected beat
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_beat: got %h expected no beat", {out_last, out_data});
      end else begin
        checkOutput("beat", {out_last, out_data}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] d, held;
    logic [64:0] held_out;
    logic [2:0]  m;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_last = 1'b0; out_ready = 1'b1;
    d8_in_data = '0; d8_in_mode = '0; d8_in_last = 1'b0; d8_in_valid = 1'b0; d8_out_ready = 1'b1;
    held = '0;
    held_out = '0;

    vecs[0] = '{pack4(0, 256, 1024, -1024),        3'd3, 1'b0, pack4(128, 170, 256, 0)};
    vecs[1] = '{pack4(0, 256, -512, 1024),         3'd4, 1'b0, pack4(0, 170, -86, 1024)};
    vecs[2] = '{pack4(-1024, -768, 768, 1536),     3'd4, 1'b1, pack4(0, 0, 768, 1536)};
    vecs[3] = '{pack4(2000, -1, 100, 1536),        3'd2, 1'b0, pack4(1536, 0, 100, 1536)};
    vecs[4] = '{pack4(-5, 5, -32768, 32767),       3'd1, 1'b1, pack4(0, 5, 0, 32767)};
    vecs[5] = '{pack4(-5, 32767, -32768, 7),       3'd0, 1'b0, pack4(-5, 32767, -32768, 7)};
    vecs[6] = '{pack4(1000, -3, 5, 9),             3'd6, 1'b0, 64'd0};
    vecs[7] = '{pack4(1, 2, 3, 4),                 3'd5, 1'b0, 64'd0};
    vecs[8] = '{pack4(-1, -2, -3, -4),             3'd7, 1'b1, 64'd0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 65'(out_valid), 65'(0));
    checkOutput("rst_out_data",  {out_last, out_data}, 65'(0));
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 65'(in_ready), 65'(1));

    // Latency: out_valid appears in the third cycle after the accept cycle
    applyStimulus(vecs[0].data, vecs[0].mode, vecs[0].last, vecs[0].exp);
    in_valid = 1'b0;
    @(negedge clk) checkOutput("lat_c1", 65'(out_valid), 65'(0));
    @(negedge clk) checkOutput("lat_c2", 65'(out_valid), 65'(0));
    @(negedge clk) checkOutput("lat_c3", 65'(out_valid), 65'(1));
    @(posedge clk);
    #1;

    for (int i = 1; i < 9; i++) applyStimulus(vecs[i].data, vecs[i].mode, vecs[i].last, vecs[i].exp);
    in_valid = 1'b0;
    waitDrain("drain_table");

    // Backpressure: 8 random beats with a 5-cycle output stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = {$urandom, $urandom};
          m = 3'($urandom_range(0, 7));
          applyStimulus(d, m, (i == 3 || i == 7), model_beat(d, m));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 65'(in_ready), 65'(0));
          if (k == 0) begin
            held_out = {out_last, out_data};
            checkOutput("stall_valid", 65'(out_valid), 65'(1));
          end else begin
            checkOutput("stall_hold", {out_last, out_data}, held_out);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_stream");

    // Reset with three beats in flight discards them all
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      applyStimulus(d, 3'd0, 1'b1, d);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 65'(out_valid), 65'(0));
    checkOutput("midrst_out_data", {out_last, out_data}, 65'(0));
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 65'(in_ready), 65'(1));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", 65'(out_valid), 65'(0));
    end

    // Narrow lanes: x=127 HSWISH stays at the positive limit, other lanes unaffected
    runD8("d8_hswish", 32'h0010_807F, 3'd4, 32'h000A_007F);
    runD8("d8_relu6",  32'h6032_807F, 3'd2, 32'h6032_0060);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hard_act_pipe.md
HARD_ACT_PIPE -- requirements
Module: hard_act_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed lane width in bits.
REQ-002 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of the lane Q-format.
REQ-003 SHALL have parameter LANES, default 4, meaning parallel elements per beat.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_data  input  LANES*DATA_WIDTH  packed signed lanes, lane 0 in LSBs.
REQ-007 SHALL have port in_mode  input  3  activation select for this beat (act_mode_e).
REQ-008 SHALL have port in_last  input  1  end-of-tile sideband, passed through unchanged.
REQ-009 SHALL have port in_valid  input  1  beat present.
REQ-010 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port out_data  output  LANES*DATA_WIDTH  activated lanes, same packing.
REQ-012 SHALL have port out_last  output  1  delayed in_last.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.

Function
REQ-015 SHALL use modes 0 BYPASS (y=x), 1 RELU, 2 RELU6, 3 HSIGMOID, 4 HSWISH; modes 5-7 SHALL output 0.
REQ-016 SHALL compute t = clamp(x + 3*2^FRAC_BITS, 0, 6*2^FRAC_BITS) per lane; RELU6 = clamp(x, 0, 6*2^FRAC_BITS).
REQ-017 SHALL compute HSIGMOID = (t*R6) >>> 16 and HSWISH = (x*t*R6) >>> (FRAC_BITS+16), with R6 = 10923 (round(2^16/6)); no divider.
REQ-018 SHALL use arithmetic (floor) right shifts, intermediates at least 2*DATA_WIDTH+18 bits wide, and no rounding.
REQ-019 SHALL saturate every result to signed DATA_WIDTH range.
REQ-020 SHALL be a 3-stage pipeline: S1 clamp, S2 multiply, S3 scale/select/saturate; latency is 3 cycles from accept to out_valid when unstalled.
REQ-021 SHALL register mode and last alongside data in every stage; beats of different mode MAY be adjacent.
REQ-022 SHALL advance all stages together when adv = out_ready | ~out_valid; in_ready SHALL equal adv.
REQ-023 SHALL clear empty stages' valid bits so bubbles collapse: any stage SHALL load when adv is high, and otherwise hold.
REQ-024 SHALL hold out_data, out_last and out_mode-derived values stable while out_valid & ~out_ready.
REQ-025 SHALL sustain one beat per cycle with out_ready held high, without loss or duplication.
REQ-026 SHALL drop no accepted beat; in_data SHALL be ignored when in_valid is low.

Reset
REQ-027 SHALL asynchronously clear all stage valid bits, out_valid, out_data and out_last to 0 on rst high.
REQ-028 SHALL discard in-flight beats when rst asserts mid-operation; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-029 SHALL place act_mode_e, R6 and the reciprocal shift constant (16) in shared package act_pkg.
REQ-030 SHALL instantiate LANES copies of sub-module act_lane, the per-lane datapath; control and valid logic SHALL stay in hard_act_pipe.

Verification
REQ-031 SHALL cover HSIGMOID with FRAC_BITS=8: x=0 -> 128; x=256 -> 170; x=1024 -> 256; x=-1024 -> 0.
REQ-032 SHALL cover HSWISH: x=0 -> 0; x=256 -> 170; x=-512 -> -86; x=1024 -> 1024; x=-1024 -> 0.
REQ-033 SHALL cover RELU6 x=2000 -> 1536, RELU x=-5 -> 0, BYPASS x=-5 -> -5, and mode 6 -> 0, in back-to-back beats.
REQ-034 SHALL cover backpressure: 8 beats streamed, out_ready low for 5 cycles mid-stream -> in_ready low and output held stable, all 8 beats in order with correct out_last.
REQ-035 SHALL cover reset: rst asserted with 3 beats in flight -> out_valid 0 immediately, no stale beat after release.
REQ-036 SHALL cover saturation: DATA_WIDTH=8, FRAC_BITS=4, HSWISH x=127 -> 127, lanes independent.
